// File: rtl/alu_arbiter_if.sv
// Requester, shared-ALU and response signals of the two-requester ALU arbiter.
interface alu_arbiter_if;
    localparam int unsigned REQ_N  = 2;
    localparam int unsigned OP_W   = 4;
    localparam int unsigned SRC_W  = 2;
    localparam int unsigned DATA_W = 8;

    logic [REQ_N-1:0]  req_valid;
    logic [OP_W-1:0]   req_op0;
    logic [OP_W-1:0]   req_op1;
    logic [SRC_W-1:0]  req_src0;
    logic [SRC_W-1:0]  req_src1;
    logic [REQ_N-1:0]  req_ready;
    logic [OP_W-1:0]   alu_op;
    logic [SRC_W-1:0]  alu_src;
    logic [DATA_W-1:0] alu_out;
    logic              rsp_valid;
    logic              rsp_id;
    logic [DATA_W-1:0] rsp_data;
    logic              rsp_ready;
    logic              busy;

    // Arbiter side.
    modport slave (
        input  req_valid, req_op0, req_op1, req_src0, req_src1, alu_out, rsp_ready,
        output req_ready, alu_op, alu_src, rsp_valid, rsp_id, rsp_data, busy
    );

    // Requester / ALU / consumer side.
    modport master (
        output req_valid, req_op0, req_op1, req_src0, req_src1, alu_out, rsp_ready,
        input  req_ready, alu_op, alu_src, rsp_valid, rsp_id, rsp_data, busy
    );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one ALU between two requesters.
// One operation in flight: IDLE (grant) -> EXEC (ALU settles) -> RESP (hold until taken).
module alu_arbiter #(
    parameter logic RR_INIT = 1'b0
) (
    input logic         clock,
    input logic         reset,
    alu_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t     state_q;
    state_t     state_d;
    logic       ptr_q;
    logic [1:0] grant_c;
    logic       grant_id;
    logic       accept;
    logic       rsp_done;

    // Grant selection and next-state decode.
    always_comb begin
        grant_c  = 2'b00;
        grant_id = 1'b0;
        state_d  = state_q;
        if ((state_q == IDLE) && !reset) begin
            case (bus.req_valid)
                2'b01: begin
                    grant_c  = 2'b01;
                    grant_id = 1'b0;
                end
                2'b10: begin
                    grant_c  = 2'b10;
                    grant_id = 1'b1;
                end
                2'b11: begin
                    grant_c  = ptr_q ? 2'b10 : 2'b01;
                    grant_id = ptr_q;
                end
                default: begin
                    grant_c  = 2'b00;
                    grant_id = 1'b0;
                end
            endcase
        end
        case (state_q)
            IDLE:    if (|grant_c) state_d = EXEC;
            EXEC:    state_d = RESP;
            RESP:    if (bus.rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign accept        = |(bus.req_valid & grant_c);
    assign rsp_done      = (state_q == RESP) && bus.rsp_ready;
    assign bus.req_ready = grant_c;
    assign bus.rsp_valid = (state_q == RESP);
    assign bus.busy      = (state_q != IDLE);

    // State, priority pointer and datapath registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= IDLE;
            ptr_q        <= RR_INIT;
            bus.alu_op   <= '0;
            bus.alu_src  <= '0;
            bus.rsp_id   <= 1'b0;
            bus.rsp_data <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                bus.alu_op  <= grant_id ? bus.req_op1 : bus.req_op0;
                bus.alu_src <= grant_id ? bus.req_src1 : bus.req_src0;
                bus.rsp_id  <= grant_id;
            end
            if (state_q == EXEC) begin
                bus.rsp_data <= bus.alu_out;
            end
            if (rsp_done) begin
                ptr_q <= ~bus.rsp_id;
            end
        end
    end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter RR_INIT, default 1'b0, requester index holding priority after reset.
REQ-002 clock  input  1  sole clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 req_valid  input  2  per-requester request strobe; bit i = requester i.
REQ-005 req_op0 / req_op1  input  ALU_OP  requested operation, requester 0 / 1.
REQ-006 req_src0 / req_src1  input  ALU_SRC  requested operand source, requester 0 / 1.
REQ-007 req_ready  output  2  accept strobe; at most one bit high per cycle.
REQ-008 alu_op  output  ALU_OP  registered operation driven to the shared ALU unit.
REQ-009 alu_src  output  ALU_SRC  registered source select driven to the shared ALU unit.
REQ-010 alu_out  input  BYTE (8)  combinational result from the shared ALU unit.
REQ-011 rsp_valid  output  1  result available.
REQ-012 rsp_id  output  1  index of the requester owning the result.
REQ-013 rsp_data  output  BYTE (8)  captured ALU result.
REQ-014 rsp_ready  input  1  consumer accepts the result.
REQ-015 busy  output  1  high in any state other than IDLE.

Function
REQ-016 The block SHALL implement the states IDLE, EXEC and RESP.
REQ-017 In IDLE, req_ready SHALL be asserted for one requester only, combinationally.
  - Sole valid requester: that requester is granted.
  - Both valid: the requester selected by the priority pointer is granted.
REQ-018 Accept = req_valid[i] & req_ready[i].
  - On accept, req_op_i -> alu_op, req_src_i -> alu_src, i -> rsp_id, all registered.
  - State -> EXEC.
REQ-019 req_ready SHALL be 0 in EXEC and RESP.
REQ-020 In EXEC, which lasts exactly one cycle, alu_out SHALL be captured into rsp_data at the clock edge ending the cycle, and the state SHALL go to RESP.
REQ-021 In RESP, rsp_valid SHALL be 1, and rsp_data and rsp_id SHALL be held stable until rsp_ready is 1.
REQ-022 On rsp_valid & rsp_ready:
  - State -> IDLE.
  - Priority pointer -> ~rsp_id (round-robin).
REQ-023 Latency SHALL be fixed: accept at edge N, rsp_valid high from cycle N+2.
  - Minimum 3 cycles per operation; no new accept in the same cycle as a response handshake.
REQ-024 alu_op and alu_src SHALL hold their last values outside an accept and SHALL change only on accept.
REQ-025 With no valid request in IDLE, the state SHALL stay IDLE and all outputs SHALL hold.
REQ-026 Requester inputs SHALL be sampled only at accept; changes before accept SHALL be ignored, and a valid dropped before grant SHALL be lost without error.
REQ-027 rsp_ready asserted outside RESP SHALL have no effect.
REQ-028 A new req_valid from the response owner during RESP SHALL wait for IDLE and then compete under the updated pointer.

Reset
REQ-029 While reset is high at a clock edge, the block SHALL set:
  - state = IDLE
  - pointer = RR_INIT
  - alu_op = 0, alu_src = 0
  - rsp_data = 8'h00, rsp_id = 0
  - rsp_valid = 0, busy = 0
REQ-030 While reset is high, req_ready SHALL be 2'b00.
REQ-031 Reset in EXEC or RESP SHALL abort the operation and emit no response; the first cycle after reset SHALL be IDLE.

Verification
REQ-032 Single request:
  - Stimulus: req_valid=2'b01 (op A, src 2), alu_out=8'h5A during EXEC, rsp_ready=1.
  - Response: req_ready=2'b01 at cycle 0; alu_src=2 at cycle 1; rsp_valid=1, rsp_data=8'h5A, rsp_id=0 at cycle 2; busy=0 at cycle 3.
REQ-033 Contention:
  - Stimulus: req_valid=2'b11 held for 4 operations, RR_INIT=0.
  - Response: grants in order 0,1,0,1; each grant 3 cycles apart.
REQ-034 Backpressure:
  - Stimulus: rsp_ready=0 for 5 cycles in RESP, alu_out toggled meanwhile.
  - Response: rsp_data, rsp_id and alu_op stable; req_ready=2'b00 throughout; IDLE one cycle after rsp_ready=1.
REQ-035 Reset mid-operation:
  - Stimulus: reset=1 for 1 cycle while in EXEC.
  - Response: rsp_valid never rises for that request; all outputs at reset values; next request accepted normally.
REQ-036 Withdrawn request:
  - Stimulus: req_valid[1] pulsed during RESP of requester 0, then dropped.
  - Response: requester 1 never granted; state returns to IDLE and stays there.
REQ-037 Reset priority:
  - Stimulus: RR_INIT=1, req_valid=2'b11 in the first cycle after reset.
  - Response: req_ready=2'b10.
